// File: rtl/parking_counter.sv
// rtl/parking_counter.sv - debounced two-sensor lane tracker with saturating occupancy counter
module parking_counter #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 15,
  parameter int DEBOUNCE = 2,
  localparam int CNT_W   = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clr_err,
  output logic [LANES-1:0] inc,
  output logic [LANES-1:0] dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  // Four extra bits leave room for +/-LANES (max 8) around the count without wrap.
  localparam int SUM_W = CNT_W + 4;

  // One-hot lane states; suffix is the filtered (a,b) pair seen in that state.
  typedef enum logic [6:0] {
    IDLE = 7'b0000001,
    E_10 = 7'b0000010,
    E_11 = 7'b0000100,
    E_01 = 7'b0001000,
    X_01 = 7'b0010000,
    X_11 = 7'b0100000,
    X_10 = 7'b1000000
  } state_t;

  state_t           state_q [LANES];
  state_t           state_d [LANES];
  logic [LANES-1:0] fa_q, fa_d;
  logic [LANES-1:0] fb_q, fb_d;
  logic [3:0]       ca_q [LANES];
  logic [3:0]       ca_d [LANES];
  logic [3:0]       cb_q [LANES];
  logic [3:0]       cb_d [LANES];
  logic [LANES-1:0] inc_q, inc_d;
  logic [LANES-1:0] dec_q, dec_d;
  logic [LANES-1:0] jump_err;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             clamp;
  logic [SUM_W-1:0] n_inc, n_dec;
  logic signed [SUM_W-1:0] sum;

  // One debounce step: returns {filtered bit, run counter}. The run restarts
  // whenever the raw bit agrees with the filtered bit.
  function automatic logic [4:0] deb_step(input logic raw, input logic filt,
                                          input logic [3:0] run);
    logic [4:0] nxt;
    if (raw == filt) begin
      nxt = {filt, 4'd0};
    end else if (({1'b0, run} + 5'd1) >= 5'(DEBOUNCE)) begin
      nxt = {raw, 4'd0};
    end else begin
      nxt = {filt, run + 4'd1};
    end
    return nxt;
  endfunction

  // Per-lane debounce filters on both sensors.
  always_comb begin
    fa_d = fa_q;
    fb_d = fb_q;
    for (int i = 0; i < LANES; i++) begin
      {fa_d[i], ca_d[i]} = deb_step(a[i], fa_q[i], ca_q[i]);
      {fb_d[i], cb_d[i]} = deb_step(b[i], fb_q[i], cb_q[i]);
    end
  end

  // Per-lane entry/exit sequence tracking on the filtered sensor pair.
  always_comb begin
    logic [1:0] ab;
    ab       = 2'b00;
    inc_d    = '0;
    dec_d    = '0;
    jump_err = '0;
    for (int i = 0; i < LANES; i++) begin
      ab          = {fa_q[i], fb_q[i]};
      state_d[i]  = state_q[i];
      unique case (state_q[i])
        IDLE: begin
          case (ab)
            2'b10:   state_d[i] = E_10;
            2'b01:   state_d[i] = X_01;
            2'b11:   jump_err[i] = 1'b1;
            default: state_d[i] = IDLE;
          endcase
        end
        E_10: begin
          case (ab)
            2'b11:   state_d[i] = E_11;
            2'b00:   state_d[i] = IDLE;
            2'b01:   begin state_d[i] = IDLE; jump_err[i] = 1'b1; end
            default: state_d[i] = E_10;
          endcase
        end
        E_11: begin
          case (ab)
            2'b01:   state_d[i] = E_01;
            2'b10:   state_d[i] = E_10;
            2'b00:   state_d[i] = IDLE;
            default: state_d[i] = E_11;
          endcase
        end
        E_01: begin
          case (ab)
            2'b00:   begin state_d[i] = IDLE; inc_d[i] = 1'b1; end
            2'b11:   state_d[i] = E_11;
            2'b10:   begin state_d[i] = IDLE; jump_err[i] = 1'b1; end
            default: state_d[i] = E_01;
          endcase
        end
        X_01: begin
          case (ab)
            2'b11:   state_d[i] = X_11;
            2'b00:   state_d[i] = IDLE;
            2'b10:   begin state_d[i] = IDLE; jump_err[i] = 1'b1; end
            default: state_d[i] = X_01;
          endcase
        end
        X_11: begin
          case (ab)
            2'b10:   state_d[i] = X_10;
            2'b01:   state_d[i] = X_01;
            2'b00:   state_d[i] = IDLE;
            default: state_d[i] = X_11;
          endcase
        end
        X_10: begin
          case (ab)
            2'b00:   begin state_d[i] = IDLE; dec_d[i] = 1'b1; end
            2'b11:   state_d[i] = X_11;
            2'b01:   begin state_d[i] = IDLE; jump_err[i] = 1'b1; end
            default: state_d[i] = X_10;
          endcase
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Net all lane pulses first, then saturate to [0, CAPACITY].
  always_comb begin
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < LANES; i++) begin
      n_inc = n_inc + SUM_W'(inc_q[i]);
      n_dec = n_dec + SUM_W'(dec_q[i]);
    end
    sum   = $signed({4'b0000, count_q}) + $signed(n_inc) - $signed(n_dec);
    clamp = 1'b0;
    if (sum[SUM_W-1]) begin
      count_d = '0;
      clamp   = 1'b1;
    end else if (sum > $signed(SUM_W'(CAPACITY))) begin
      count_d = CNT_W'(CAPACITY);
      clamp   = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  // Sticky error: a new set condition overrides a simultaneous clear.
  always_comb begin
    err_d = clamp | (|jump_err) | (err_q & ~clr_err);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= IDLE;
        ca_q[i]    <= 4'd0;
        cb_q[i]    <= 4'd0;
      end
      fa_q    <= '0;
      fb_q    <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        ca_q[i]    <= ca_d[i];
        cb_q[i]    <= cb_d[i];
      end
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign inc   = inc_q;
  assign dec   = dec_q;
  assign count = count_q;
  assign full  = (count_q == CNT_W'(CAPACITY));
  assign empty = (count_q == '0);
  assign err   = err_q;

endmodule

// File: tb/tb_parking_counter.sv
// tb/tb_parking_counter.sv - scoreboard bench for parking_counter (LANES=2, CAPACITY=3, DEBOUNCE=2)
module tb_parking_counter;

  localparam int LANES    = 2;
  localparam int CAPACITY = 3;
  localparam int DEBOUNCE = 2;
  localparam int CNT_W    = $clog2(CAPACITY + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [LANES-1:0] a, b;
  logic             clr_err;
  logic [LANES-1:0] inc, dec;
  logic [CNT_W-1:0] count;
  logic             full, empty, err;

  int vectors = 0;
  int fails   = 0;
  int n_inc0 = 0, n_inc1 = 0, n_dec0 = 0, n_dec1 = 0;

  typedef struct {
    string tag;
    int    inc0, inc1, dec0, dec1;
    int    cnt, emp, ful, er;
    int    b_inc0, b_inc1, b_dec0, b_dec1;
  } exp_t;

  exp_t sb[$];

  parking_counter #(.LANES(LANES), .CAPACITY(CAPACITY), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr_err(clr_err),
    .inc(inc), .dec(dec), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc[0]) n_inc0++;
    if (inc[1]) n_inc1++;
    if (dec[0]) n_dec0++;
    if (dec[1]) n_dec1++;
  end

  task automatic check(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] bv, input int cyc);
    a = av;
    b = bv;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input string tag, input int i0, input int i1, input int d0,
                             input int d1, input int c, input int e, input int f, input int er);
    exp_t x;
    x.tag = tag; x.inc0 = i0; x.inc1 = i1; x.dec0 = d0; x.dec1 = d1;
    x.cnt = c; x.emp = e; x.ful = f; x.er = er;
    x.b_inc0 = n_inc0; x.b_inc1 = n_inc1; x.b_dec0 = n_dec0; x.b_dec1 = n_dec1;
    sb.push_back(x);
  endtask

  task automatic check_step();
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    x = sb.pop_front();
    check({x.tag, ".inc0"}, n_inc0 - x.b_inc0, x.inc0);
    check({x.tag, ".inc1"}, n_inc1 - x.b_inc1, x.inc1);
    check({x.tag, ".dec0"}, n_dec0 - x.b_dec0, x.dec0);
    check({x.tag, ".dec1"}, n_dec1 - x.b_dec1, x.dec1);
    check({x.tag, ".count"}, int'(count), x.cnt);
    check({x.tag, ".empty"}, int'(empty), x.emp);
    check({x.tag, ".full"},  int'(full),  x.ful);
    check({x.tag, ".err"},   int'(err),   x.er);
  endtask

  task automatic entry0();
    drive(2'b01, 2'b00, 4);
    drive(2'b01, 2'b01, 4);
    drive(2'b00, 2'b01, 4);
    drive(2'b00, 2'b00, 6);
  endtask

  initial begin
    reset = 1'b1; clr_err = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 3);

    // Reset state
    check("rst.count", int'(count), 0);
    check("rst.empty", int'(empty), 1);
    check("rst.full",  int'(full),  0);
    check("rst.err",   int'(err),   0);
    check("rst.pulses", int'({inc, dec}), 0);
    reset = 1'b0;
    drive(2'b00, 2'b00, 2);

    // Lane 0 entry
    expect_step("entry0", 1, 0, 0, 0, 1, 0, 0, 0);
    entry0();
    check_step();

    // Lane 1 exit
    expect_step("exit1", 0, 0, 0, 1, 0, 1, 0, 0);
    drive(2'b00, 2'b10, 4);
    drive(2'b10, 2'b10, 4);
    drive(2'b10, 2'b00, 4);
    drive(2'b00, 2'b00, 6);
    check_step();

    // One-cycle glitch is filtered out
    expect_step("glitch", 0, 0, 0, 0, 0, 1, 0, 0);
    drive(2'b01, 2'b00, 1);
    drive(2'b00, 2'b00, 8);
    check_step();

    // Fill to capacity
    expect_step("fill", 3, 0, 0, 0, 3, 0, 1, 0);
    entry0();
    entry0();
    entry0();
    check_step();

    // Two simultaneous entries at capacity saturate and flag err
    expect_step("overflow", 1, 1, 0, 0, 3, 0, 1, 1);
    drive(2'b11, 2'b00, 4);
    drive(2'b11, 2'b11, 4);
    drive(2'b00, 2'b11, 4);
    drive(2'b00, 2'b00, 6);
    check_step();

    expect_step("clr_err", 0, 0, 0, 0, 3, 0, 1, 0);
    clr_err = 1'b1;
    drive(2'b00, 2'b00, 1);
    clr_err = 1'b0;
    drive(2'b00, 2'b00, 2);
    check_step();

    // Abort mid-entry: no pulse, no err
    expect_step("abort", 0, 0, 0, 0, 3, 0, 1, 0);
    drive(2'b01, 2'b00, 4);
    drive(2'b01, 2'b01, 4);
    drive(2'b00, 2'b00, 8);
    check_step();

    // Illegal jump 10 -> 01 sets err
    expect_step("jump", 0, 0, 0, 0, 3, 0, 1, 1);
    drive(2'b01, 2'b00, 4);
    drive(2'b00, 2'b01, 4);
    drive(2'b00, 2'b00, 8);
    check_step();

    // Lane 0 returned to IDLE: a clean exit is tracked
    expect_step("exit0", 0, 0, 1, 0, 2, 0, 0, 0);
    clr_err = 1'b1;
    drive(2'b00, 2'b00, 1);
    clr_err = 1'b0;
    drive(2'b00, 2'b01, 4);
    drive(2'b01, 2'b01, 4);
    drive(2'b01, 2'b00, 4);
    drive(2'b00, 2'b00, 6);
    check_step();

    // Reset while lane 0 sits in E_01
    expect_step("rst_mid", 0, 0, 0, 0, 0, 1, 0, 0);
    drive(2'b01, 2'b00, 4);
    drive(2'b01, 2'b01, 4);
    drive(2'b00, 2'b01, 4);
    reset = 1'b1;
    drive(2'b00, 2'b00, 3);
    reset = 1'b0;
    drive(2'b00, 2'b00, 8);
    check_step();

    // Entry and exit completing together at count 0 net to zero
    expect_step("net", 1, 0, 0, 1, 0, 1, 0, 0);
    drive(2'b01, 2'b10, 4);
    drive(2'b11, 2'b11, 4);
    drive(2'b10, 2'b01, 4);
    drive(2'b00, 2'b00, 6);
    check_step();

    // Sensor held blocked through reset release is picked up fresh
    expect_step("held", 1, 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    drive(2'b01, 2'b00, 3);
    reset = 1'b0;
    drive(2'b01, 2'b00, 4);
    drive(2'b01, 2'b01, 4);
    drive(2'b00, 2'b01, 4);
    drive(2'b00, 2'b00, 6);
    check_step();

    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/parking_counter.md
PARKING_COUNTER -- requirements
Module: parking_counter

Interface
REQ-001 Parameter LANES, default 2, number of independent two-sensor lanes (1..8).
REQ-002 Parameter CAPACITY, default 15, maximum occupancy (1..255).
REQ-003 Parameter DEBOUNCE, default 2, consecutive stable cycles required before a raw sensor change is accepted (1..15).
REQ-004 Derived CNT_W = $clog2(CAPACITY+1), not overridable.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 a  input  LANES  per-lane outer sensor, 1 = beam blocked.
REQ-008 b  input  LANES  per-lane inner sensor, 1 = beam blocked.
REQ-009 clr_err  input  1  synchronous clear of err.
REQ-010 inc  output  LANES  one-cycle pulse per completed entry on that lane.
REQ-011 dec  output  LANES  one-cycle pulse per completed exit on that lane.
REQ-012 count  output  CNT_W  current occupancy.
REQ-013 full  output  1  high when count == CAPACITY.
REQ-014 empty  output  1  high when count == 0.
REQ-015 err  output  1  sticky; set on clamped update or illegal sensor jump.

Function
REQ-016 Each lane's a and b shall pass through an independent debounce filter: the filtered bit takes the raw value only after the raw value has differed from it for DEBOUNCE consecutive cycles; any intermediate match restarts the run counter.
REQ-017 Each lane shall run a one-hot FSM on filtered (a,b) with states IDLE, E_10, E_11, E_01, X_01, X_11, X_10 (suffix = a,b).
REQ-018 IDLE: (1,0)->E_10; (0,1)->X_01; (0,0) stay; (1,1)->stay IDLE and set err.
REQ-019 Entry path: E_10 -(1,1)-> E_11 -(0,1)-> E_01 -(0,0)-> IDLE with inc pulse; backward moves E_11-(1,0)->E_10, E_01-(1,1)->E_11 allowed.
REQ-020 Exit path mirrors entry: X_01 -(1,1)-> X_11 -(1,0)-> X_10 -(0,0)-> IDLE with dec pulse; backward moves X_11-(0,1)->X_01, X_10-(1,1)->X_11 allowed.
REQ-021 Abort: (0,0) from E_10, E_11, X_01 or X_11 shall return to IDLE with no pulse and no err.
REQ-022 Any other two-bit jump (e.g. E_10 seeing (0,1)) shall return to IDLE and set err.
REQ-023 inc[i]/dec[i] shall be registered, high exactly the one cycle after the completing transition is sampled.
REQ-024 Every cycle count_next = clamp(count + popcount(inc) - popcount(dec), 0, CAPACITY), computed at width CNT_W+4 signed; count updates one cycle after the pulses.
REQ-025 Simultaneous inc and dec pulses (same or different lanes) shall net before clamping; e.g. 2 inc + 1 dec at count=CAPACITY-1 -> CAPACITY, no err.
REQ-026 If the unclamped result is >CAPACITY or <0, count saturates and err sets the same cycle count updates.
REQ-027 full and empty shall decode directly from the count register.
REQ-028 err clears on clr_err; a set condition in the same cycle as clr_err wins (err stays 1).
REQ-029 Lanes shall be fully independent; no lane stalls or arbitrates another.

Reset
REQ-030 While reset is high: all FSMs IDLE, filtered bits and debounce counters 0, inc=dec=0, count=0, empty=1, full=0, err=0.
REQ-031 Reset asserted mid-sequence shall abandon the sequence; no pulse shall emit for it after release.
REQ-032 After reset deasserts, sensors held at 1 are processed as fresh input through debounce.

Verification (LANES=2, CAPACITY=3, DEBOUNCE=2)
REQ-033 Lane 0 drives (a,b) 10,11,01,00, each held 4 cycles -> one inc[0] pulse, count 0->1, empty falls, err=0.
REQ-034 Lane 1 drives 01,11,10,00 at count=1 -> one dec[1] pulse, count 1->0, empty rises.
REQ-035 Lane 0 drives 10 for 1 cycle then 00 (glitch) -> FSM stays IDLE, no pulse, count unchanged.
REQ-036 count=3, both lanes complete entries in the same cycle -> count stays 3, full=1, err=1; clr_err then clears err.
REQ-037 Lane 0 drives 10,11 then 00 -> abort to IDLE, no inc, err=0; then drives 10 then 01 -> err=1, FSM IDLE.
REQ-038 Reset asserted while lane 0 is in E_01, released with sensors 00 -> no inc, count=0.
